// File: rtl/branch_predictor_pkg.sv
// rtl/branch_predictor_pkg.sv - shared types and defaults for the branch predictor
package branch_predictor_pkg;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      STT = 2'b11
   } bht_state_t;

   localparam bht_state_t BHT_INIT    = WNT;
   localparam int         BHT_ENTRIES = 32;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// rtl/branch_predictor_sat_counter2.sv - 2-bit saturating counter next-state function
module sat_counter2
   import branch_predictor_pkg::*;
(
   input  bht_state_t state,
   input  logic       taken,
   output bht_state_t next_state
);

   always_comb begin
      next_state = state;
      unique case (state)
         SNT: next_state = taken ? WNT : SNT;
         WNT: next_state = taken ? WT  : SNT;
         WT:  next_state = taken ? STT : WNT;
         STT: next_state = taken ? STT : WT;
         default: next_state = state;
      endcase
   end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - untagged 2-bit BHT with EX-stage training and miss redirect
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int ENTRIES = BHT_ENTRIES,
   parameter int IDX_WID = $clog2(ENTRIES)
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] ID_pc,
   input  logic        ID_is_branch,
   output logic        predict_taken,
   input  logic        old_branch,
   input  logic        branch_result,
   input  logic        old_predict,
   input  logic [31:0] old_pc,
   input  logic [31:0] EX_target,
   input  logic        EX_stall,
   output logic        mispredict,
   output logic [31:0] redirect_pc,
   output logic [31:0] branch_cnt,
   output logic [31:0] miss_cnt
);

   bht_state_t         bht [ENTRIES];
   bht_state_t         rd_state;
   bht_state_t         wr_next;
   logic [1:0]         rd_bits;
   logic [IDX_WID-1:0] rd_idx;
   logic [IDX_WID-1:0] wr_idx;
   logic               upd;
   logic               unused_pc_bits;

   assign rd_idx = ID_pc[IDX_WID+1:2];
   assign wr_idx = old_pc[IDX_WID+1:2];
   assign unused_pc_bits = ^{ID_pc[31:IDX_WID+2], ID_pc[1:0]};

   // Read is the registered table value; a same-cycle write is not bypassed.
   assign rd_state      = bht[rd_idx];
   assign rd_bits       = rd_state;
   assign predict_taken = ID_is_branch & rd_bits[1];

   assign upd         = old_branch & ~EX_stall;
   assign mispredict  = upd & (branch_result ^ old_predict);
   assign redirect_pc = mispredict ? (branch_result ? EX_target : old_pc + 32'd4) : 32'd0;

   sat_counter2 u_sat_counter2 (
      .state      (bht[wr_idx]),
      .taken      (branch_result),
      .next_state (wr_next)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            bht[i] <= BHT_INIT;
         end
         branch_cnt <= 32'd0;
         miss_cnt   <= 32'd0;
      end else if (upd) begin
         bht[wr_idx] <= wr_next;
         if (branch_cnt != 32'hFFFF_FFFF) begin
            branch_cnt <= branch_cnt + 32'd1;
         end
         if (mispredict && miss_cnt != 32'hFFFF_FFFF) begin
            miss_cnt <= miss_cnt + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - scoreboard bench for branch_predictor against a counter-array model
module tb_branch_predictor;

   localparam int ENTRIES = 32;

   logic        clk;
   logic        rst_n;
   logic [31:0] ID_pc;
   logic        ID_is_branch;
   logic        predict_taken;
   logic        old_branch;
   logic        branch_result;
   logic        old_predict;
   logic [31:0] old_pc;
   logic [31:0] EX_target;
   logic        EX_stall;
   logic        mispredict;
   logic [31:0] redirect_pc;
   logic [31:0] branch_cnt;
   logic [31:0] miss_cnt;

   typedef struct {
      logic        pred;
      logic        mis;
      logic [31:0] redir;
      logic [31:0] bcnt;
      logic [31:0] mcnt;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;

   int          m_tbl [ENTRIES];
   longint      m_bcnt;
   longint      m_mcnt;

   branch_predictor #(.ENTRIES(ENTRIES)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .ID_pc         (ID_pc),
      .ID_is_branch  (ID_is_branch),
      .predict_taken (predict_taken),
      .old_branch    (old_branch),
      .branch_result (branch_result),
      .old_predict   (old_predict),
      .old_pc        (old_pc),
      .EX_target     (EX_target),
      .EX_stall      (EX_stall),
      .mispredict    (mispredict),
      .redirect_pc   (redirect_pc),
      .branch_cnt    (branch_cnt),
      .miss_cnt      (miss_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int idx(input logic [31:0] pc);
      return int'((pc >> 2) % ENTRIES);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < ENTRIES; i++) m_tbl[i] = 1;
      m_bcnt = 0;
      m_mcnt = 0;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, expv, $time);
      end
   endtask

   // One core cycle: drive inputs, queue the expected outputs, then advance the model past the edge.
   task automatic step(input logic rn, input logic [31:0] idpc, input logic idb,
                       input logic ob, input logic br, input logic op,
                       input logic [31:0] opc, input logic [31:0] tgt, input logic st);
      exp_t e;
      logic upd_m;
      int   k;
      @(posedge clk);
      #1;
      rst_n = rn; ID_pc = idpc; ID_is_branch = idb; old_branch = ob;
      branch_result = br; old_predict = op; old_pc = opc; EX_target = tgt; EX_stall = st;
      upd_m   = ob && !st;
      e.pred  = idb && (m_tbl[idx(idpc)] >= 2);
      e.mis   = upd_m && (br != op);
      e.redir = e.mis ? (br ? tgt : opc + 32'd4) : 32'd0;
      e.bcnt  = m_bcnt[31:0];
      e.mcnt  = m_mcnt[31:0];
      exp_q.push_back(e);
      if (!rn) begin
         model_reset();
      end else if (upd_m) begin
         k = idx(opc);
         m_tbl[k] = br ? ((m_tbl[k] < 3) ? m_tbl[k] + 1 : 3) : ((m_tbl[k] > 0) ? m_tbl[k] - 1 : 0);
         if (m_bcnt < 64'hFFFF_FFFF) m_bcnt++;
         if (e.mis && m_mcnt < 64'hFFFF_FFFF) m_mcnt++;
      end
   endtask

   task automatic upd_step(input logic [31:0] idpc, input logic br, input logic op, input logic [31:0] opc);
      step(1'b1, idpc, 1'b1, 1'b1, br, op, opc, 32'h80, 1'b0);
   endtask

   task automatic read_step(input logic [31:0] idpc);
      step(1'b1, idpc, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("predict_taken", {31'd0, predict_taken}, {31'd0, e.pred});
         chk("mispredict",    {31'd0, mispredict},    {31'd0, e.mis});
         chk("redirect_pc",   redirect_pc,            e.redir);
         chk("branch_cnt",    branch_cnt,             e.bcnt);
         chk("miss_cnt",      miss_cnt,               e.mcnt);
      end
   end

   initial begin
      logic [31:0] rpc;
      logic [31:0] ipc;
      rst_n = 1'b0; ID_pc = '0; ID_is_branch = 1'b0; old_branch = 1'b0;
      branch_result = 1'b0; old_predict = 1'b0; old_pc = '0; EX_target = '0; EX_stall = 1'b0;
      model_reset();

      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      read_step(32'h40);

      upd_step(32'h40, 1'b1, 1'b0, 32'h40);
      upd_step(32'h40, 1'b1, 1'b0, 32'h40);
      read_step(32'h40);

      repeat (3) upd_step(32'h40, 1'b1, 1'b0, 32'h40);
      upd_step(32'h40, 1'b0, 1'b1, 32'h40);
      read_step(32'h40);
      upd_step(32'h40, 1'b0, 1'b1, 32'h40);
      read_step(32'h40);

      upd_step(32'h44, 1'b1, 1'b0, 32'h40);
      upd_step(32'h44, 1'b1, 1'b0, 32'h40);
      read_step(32'hC0);
      read_step(32'h44);

      repeat (3) step(1'b1, 32'h40, 1'b1, 1'b1, 1'b0, 1'b1, 32'h40, 32'h80, 1'b1);
      read_step(32'h40);
      step(1'b1, 32'h40, 1'b1, 1'b0, 1'b1, 1'b0, 32'h40, 32'h80, 1'b0);
      read_step(32'h40);

      upd_step(32'h40, 1'b0, 1'b1, 32'h40);
      upd_step(32'h40, 1'b0, 1'b1, 32'h40);
      read_step(32'h40);

      upd_step(32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC);

      step(1'b0, 32'h40, 1'b1, 1'b1, 1'b1, 1'b0, 32'h40, 32'h80, 1'b0);
      read_step(32'h40);
      read_step(32'hFFFF_FFFC);

      for (int n = 0; n < 3000; n++) begin
         rpc = ($urandom_range(0, 7) == 0) ? ($urandom() & 32'hFFFF_FFFC) : ($urandom() & 32'h0000_01FC);
         ipc = ($urandom_range(0, 1) == 0) ? rpc : ($urandom() & 32'h0000_01FF);
         step(($urandom_range(0, 99) != 0), ipc, 1'($urandom()), 1'($urandom()),
              1'($urandom()), 1'($urandom()), rpc, $urandom(), ($urandom_range(0, 4) == 0));
      end

      repeat (3) @(posedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
